wb_trap_commit: RTL and testbench
=================================

# wb_trap_commit

Parametrised writeback/commit stage for the RISC-V core. It sits after the memory stage and selects register-file and CSR write data for each retiring instruction. It drives branch/jump redirects and MRET returns. It also runs a multi-cycle precise-trap sequencer, which prioritises exceptions and interrupts, writes mepc/mcause/mtval through the single CSR write port, then redirects to mtvec and flushes the pipe.

## Interface
- XLEN, 64, datapath width (32 or 64)
- CSR_AW, 12, CSR address width
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  synchronous, active-high
- WB_V  in  1  instruction in WB is valid
- WB_IR  in  32  instruction word
- WB_PC / WB_NPC  in  XLEN  PC of instruction / PC+4
- WB_ALU_RESULT / WB_MEM_RESULT  in  XLEN  ALU result (also branch/jump target) / load data
- WB_RFD / WB_CSRFD  in  XLEN  CSR-instr rd data / new CSR value
- WB_DRID  in  5  destination register
- WB_PC_MUX  in  1  branch/jump taken
- WB_BADADDR  in  XLEN  faulting address or instruction for mtval
- WB_ECALL, F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF  in  1 each  exception flags
- TIMER, EXTERNAL  in  1  interrupt requests (level)
- MIE  in  1  mstatus.MIE
- PRIVILEGE  in  1  1 = M-mode, 0 = U-mode
- MTVEC / MEPC  in  XLEN  current CSR values
- WB_RF_DATA  out  XLEN; WB_DRID_OUT  out  5; WB_ST_REG  out  1
- WB_CSR_DATA  out  XLEN; WB_CSR_ADDR  out  CSR_AW; WB_ST_CSR  out  1
- WB_BR_JMP_TARGET  out  XLEN; WB_PC_MUX_OUT  out  1  redirect
- WB_FLUSH  out  1  kill all younger stages
- WB_STALL  out  1  freeze upstream stages
- WB_CAUSE  out  XLEN  latched mcause value
- WB_CS  out  1  one-cycle trap-entry pulse (CSR file updates MPIE/MPP/MIE)

## Operation
- FSM states: IDLE, W_EPC, W_CAUSE, W_TVAL, REDIRECT.
- All outputs are registered and reset to 0. The FSM resets to IDLE.
- **IDLE, WB_V=1, no trap: normal commit**
  - Opcode 0000011: RF gets MEM_RESULT.
  - Opcodes 0010011, 0110011, 0010111, 0110111, 0011011, 0111011: RF gets ALU_RESULT.
  - Opcodes 1101111, 1100111: RF gets NPC.
  - Opcode 1110011 with funct3≠0: RF gets RFD; WB_CSR_DATA=CSRFD; WB_CSR_ADDR=IR[31:20]; ST_CSR=1.
  - Other opcodes: no writes.
  - WB_ST_REG is forced 0 when DRID=0.
  - Redirect (PC_MUX_OUT=1, target=ALU_RESULT, FLUSH=1) when WB_PC_MUX=1 on a branch or jump.
  - MRET (IR=0x30200073): redirect to MEPC with FLUSH=1, no register write.
- **Trap detect (IDLE, WB_V=1)**
  - Interrupt condition: MIE=1 and (EXTERNAL or TIMER). An interrupt outranks any exception.
  - Interrupt codes: EXTERNAL 11, then TIMER 7. The interrupt flag is bit XLEN-1.
  - Exception priority and codes: F_IAF 1, F_II 2, F_IAM 0, ECALL (11 if PRIVILEGE else 8), MEM_SAM 6, MEM_LAM 4, MEM_SAF 7, MEM_LAF 5.
  - On trap, the instruction is suppressed: no RF, CSR or branch effects.
  - Latched on trap: epc=WB_PC, cause, tval (WB_BADADDR for exceptions, 0 for interrupts and ECALL). FSM goes to W_EPC.
- **Trap sequence**
  - W_EPC: ST_CSR=1, addr 0x341, data epc.
  - W_CAUSE: ST_CSR=1, addr 0x342, data cause.
  - W_TVAL: ST_CSR=1, addr 0x343, data tval.
  - REDIRECT: PC_MUX_OUT=1, FLUSH=1, WB_CS=1.
    - Target is {MTVEC[XLEN-1:2],2'b00}.
    - If MTVEC[0]=1 and the trap is an interrupt, target is base + 4×code.
  - FSM then returns to IDLE.
- WB_STALL=1 in W_EPC, W_CAUSE and W_TVAL. WB_V and all trap inputs are ignored outside IDLE.
- WB_CAUSE holds the latched cause until the next trap. It resets to 0.

## Timing
- Normal commit: inputs sampled at edge N, outputs valid after edge N, i.e. during cycle N+1, for exactly one cycle. No stall.
- Trap detected at edge N:
  - W_EPC during cycle N+1, W_CAUSE N+2, W_TVAL N+3, REDIRECT N+4, IDLE from N+5.
  - Total stall is 3 cycles, plus 1 redirect cycle.
- Outputs with no active request in a cycle are 0 (ST_REG, ST_CSR, PC_MUX_OUT, FLUSH, CS, STALL).
- Reset asserted mid-sequence: IDLE at the next edge, all outputs 0, no partial redirect. The CSR writes already issued stand.
- Interrupt and exception in the same cycle: interrupt wins, epc=WB_PC, and the instruction retries after return.
- WB_V=0: no trap is taken, including a pending interrupt. Interrupts are taken only on a valid instruction boundary.

## Test plan
- Load, IR opcode 0000011, DRID=5, MEM_RESULT=0xDEAD -> next cycle RF_DATA=0xDEAD, DRID_OUT=5, ST_REG=1. Same with DRID=0 -> ST_REG=0.
- JAL taken, NPC=0x1004, ALU_RESULT=0x2000 -> RF_DATA=0x1004, PC_MUX_OUT=1, target 0x2000, FLUSH=1.
- F_II with PC=0x100, BADADDR=0xFFFF, MTVEC=0x8000 -> CSR writes (0x341,0x100), (0x342,2), (0x343,0xFFFF) on three consecutive cycles with STALL=1; then redirect to 0x8000 with WB_CS=1; no RF write.
- TIMER and MEM_LAF together, MIE=1, MTVEC=0x8001 -> cause 0x8000…0007, tval 0, target 0x801C.
- ECALL with PRIVILEGE=0, then again with PRIVILEGE=1 -> cause 8, then 11. Then MRET with MEPC=0x400 -> redirect to 0x400.
- RESET asserted during W_CAUSE -> next cycle all outputs 0, STALL=0, and a following normal load commits normally.

Source files
------------

// File: rtl/wb_trap_commit.sv
// Writeback/commit stage: selects RF/CSR write data, drives branch/MRET redirects
// and runs the precise-trap sequencer (mepc -> mcause -> mtval -> mtvec redirect).
module wb_trap_commit #(
    parameter int XLEN   = 64,
    parameter int CSR_AW = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WB_V,
    input  logic [31:0]       WB_IR,
    input  logic [XLEN-1:0]   WB_PC,
    input  logic [XLEN-1:0]   WB_NPC,
    input  logic [XLEN-1:0]   WB_ALU_RESULT,
    input  logic [XLEN-1:0]   WB_MEM_RESULT,
    input  logic [XLEN-1:0]   WB_RFD,
    input  logic [XLEN-1:0]   WB_CSRFD,
    input  logic [4:0]        WB_DRID,
    input  logic              WB_PC_MUX,
    input  logic [XLEN-1:0]   WB_BADADDR,
    input  logic              WB_ECALL,
    input  logic              F_IAM,
    input  logic              F_IAF,
    input  logic              F_II,
    input  logic              MEM_LAM,
    input  logic              MEM_LAF,
    input  logic              MEM_SAM,
    input  logic              MEM_SAF,
    input  logic              TIMER,
    input  logic              EXTERNAL,
    input  logic              MIE,
    input  logic              PRIVILEGE,
    input  logic [XLEN-1:0]   MTVEC,
    input  logic [XLEN-1:0]   MEPC,
    output logic [XLEN-1:0]   WB_RF_DATA,
    output logic [4:0]        WB_DRID_OUT,
    output logic              WB_ST_REG,
    output logic [XLEN-1:0]   WB_CSR_DATA,
    output logic [CSR_AW-1:0] WB_CSR_ADDR,
    output logic              WB_ST_CSR,
    output logic [XLEN-1:0]   WB_BR_JMP_TARGET,
    output logic              WB_PC_MUX_OUT,
    output logic              WB_FLUSH,
    output logic              WB_STALL,
    output logic [XLEN-1:0]   WB_CAUSE,
    output logic              WB_CS
);

    localparam logic [CSR_AW-1:0] CSR_MEPC   = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] CSR_MCAUSE = CSR_AW'(12'h342);
    localparam logic [CSR_AW-1:0] CSR_MTVAL  = CSR_AW'(12'h343);
    localparam logic [31:0]       MRET_IR    = 32'h3020_0073;

    typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_TVAL, REDIRECT} state_t;

    state_t            state;
    logic [XLEN-1:0]   epc_q, tval_q;

    logic [6:0]        opc;
    logic              is_load, is_alu, is_jmp, is_br, is_csr, is_mret;
    logic              rf_wr;
    logic [XLEN-1:0]   rf_data;
    logic              irq, exc;
    logic [XLEN-1:0]   trap_cause, trap_tval;
    logic [XLEN-1:0]   tvec_base, tvec_tgt;

    always_comb begin
        opc     = WB_IR[6:0];
        is_load = (opc == 7'b0000011);
        is_alu  = (opc == 7'b0010011) || (opc == 7'b0110011) || (opc == 7'b0010111) ||
                  (opc == 7'b0110111) || (opc == 7'b0011011) || (opc == 7'b0111011);
        is_jmp  = (opc == 7'b1101111) || (opc == 7'b1100111);
        is_br   = (opc == 7'b1100011);
        is_csr  = (opc == 7'b1110011) && (WB_IR[14:12] != 3'b000);
        is_mret = (WB_IR == MRET_IR);

        rf_wr   = is_load || is_alu || is_jmp || is_csr;
        rf_data = '0;
        if (is_load)     rf_data = WB_MEM_RESULT;
        else if (is_alu) rf_data = WB_ALU_RESULT;
        else if (is_jmp) rf_data = WB_NPC;
        else if (is_csr) rf_data = WB_RFD;
    end

    // Interrupts outrank every exception; ECALL reports no tval.
    always_comb begin
        irq        = MIE && (EXTERNAL || TIMER);
        exc        = F_IAF || F_II || F_IAM || WB_ECALL || MEM_SAM || MEM_LAM || MEM_SAF || MEM_LAF;
        trap_cause = '0;
        trap_tval  = '0;
        if (irq)            trap_cause = {1'b1, (XLEN-1)'(EXTERNAL ? 11 : 7)};
        else if (F_IAF)     begin trap_cause = XLEN'(1); trap_tval = WB_BADADDR; end
        else if (F_II)      begin trap_cause = XLEN'(2); trap_tval = WB_BADADDR; end
        else if (F_IAM)     begin trap_cause = XLEN'(0); trap_tval = WB_BADADDR; end
        else if (WB_ECALL)  trap_cause = PRIVILEGE ? XLEN'(11) : XLEN'(8);
        else if (MEM_SAM)   begin trap_cause = XLEN'(6); trap_tval = WB_BADADDR; end
        else if (MEM_LAM)   begin trap_cause = XLEN'(4); trap_tval = WB_BADADDR; end
        else if (MEM_SAF)   begin trap_cause = XLEN'(7); trap_tval = WB_BADADDR; end
        else if (MEM_LAF)   begin trap_cause = XLEN'(5); trap_tval = WB_BADADDR; end
    end

    // Vectored mode only applies to interrupts: base + 4*code.
    always_comb begin
        tvec_base = MTVEC & ~XLEN'(3);
        tvec_tgt  = tvec_base;
        if (MTVEC[0] && WB_CAUSE[XLEN-1])
            tvec_tgt = tvec_base + {WB_CAUSE[XLEN-3:0], 2'b00};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state            <= IDLE;
            epc_q            <= '0;
            tval_q           <= '0;
            WB_RF_DATA       <= '0;
            WB_DRID_OUT      <= '0;
            WB_ST_REG        <= 1'b0;
            WB_CSR_DATA      <= '0;
            WB_CSR_ADDR      <= '0;
            WB_ST_CSR        <= 1'b0;
            WB_BR_JMP_TARGET <= '0;
            WB_PC_MUX_OUT    <= 1'b0;
            WB_FLUSH         <= 1'b0;
            WB_STALL         <= 1'b0;
            WB_CAUSE         <= '0;
            WB_CS            <= 1'b0;
        end else begin
            WB_RF_DATA       <= '0;
            WB_DRID_OUT      <= '0;
            WB_ST_REG        <= 1'b0;
            WB_CSR_DATA      <= '0;
            WB_CSR_ADDR      <= '0;
            WB_ST_CSR        <= 1'b0;
            WB_BR_JMP_TARGET <= '0;
            WB_PC_MUX_OUT    <= 1'b0;
            WB_FLUSH         <= 1'b0;
            WB_STALL         <= 1'b0;
            WB_CS            <= 1'b0;
            case (state)
                IDLE: if (WB_V) begin
                    if (irq || exc) begin
                        epc_q       <= WB_PC;
                        tval_q      <= trap_tval;
                        WB_CAUSE    <= trap_cause;
                        WB_ST_CSR   <= 1'b1;
                        WB_CSR_ADDR <= CSR_MEPC;
                        WB_CSR_DATA <= WB_PC;
                        WB_STALL    <= 1'b1;
                        state       <= W_EPC;
                    end else begin
                        if (rf_wr) begin
                            WB_RF_DATA  <= rf_data;
                            WB_DRID_OUT <= WB_DRID;
                            WB_ST_REG   <= (WB_DRID != 5'd0);
                        end
                        if (is_csr) begin
                            WB_ST_CSR   <= 1'b1;
                            WB_CSR_ADDR <= CSR_AW'(WB_IR[31:20]);
                            WB_CSR_DATA <= WB_CSRFD;
                        end
                        if (WB_PC_MUX && (is_br || is_jmp)) begin
                            WB_PC_MUX_OUT    <= 1'b1;
                            WB_BR_JMP_TARGET <= WB_ALU_RESULT;
                            WB_FLUSH         <= 1'b1;
                        end else if (is_mret) begin
                            WB_PC_MUX_OUT    <= 1'b1;
                            WB_BR_JMP_TARGET <= MEPC;
                            WB_FLUSH         <= 1'b1;
                        end
                    end
                end
                W_EPC: begin
                    WB_ST_CSR   <= 1'b1;
                    WB_CSR_ADDR <= CSR_MCAUSE;
                    WB_CSR_DATA <= WB_CAUSE;
                    WB_STALL    <= 1'b1;
                    state       <= W_CAUSE;
                end
                W_CAUSE: begin
                    WB_ST_CSR   <= 1'b1;
                    WB_CSR_ADDR <= CSR_MTVAL;
                    WB_CSR_DATA <= tval_q;
                    WB_STALL    <= 1'b1;
                    state       <= W_TVAL;
                end
                W_TVAL: begin
                    WB_PC_MUX_OUT    <= 1'b1;
                    WB_BR_JMP_TARGET <= tvec_tgt;
                    WB_FLUSH         <= 1'b1;
                    WB_CS            <= 1'b1;
                    state            <= REDIRECT;
                end
                REDIRECT: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trap_commit.sv
// Directed bench for wb_trap_commit: commits, redirects, trap sequences and reset abort.
module tb_wb_trap_commit;

    localparam int XLEN = 64;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            WB_V;
    logic [31:0]     WB_IR;
    logic [63:0]     WB_PC, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_RFD, WB_CSRFD;
    logic [4:0]      WB_DRID;
    logic            WB_PC_MUX;
    logic [63:0]     WB_BADADDR;
    logic            WB_ECALL, F_IAM, F_IAF, F_II, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;
    logic            TIMER, EXTERNAL, MIE, PRIVILEGE;
    logic [63:0]     MTVEC, MEPC;
    logic [63:0]     WB_RF_DATA, WB_CSR_DATA, WB_BR_JMP_TARGET, WB_CAUSE;
    logic [4:0]      WB_DRID_OUT;
    logic            WB_ST_REG, WB_ST_CSR, WB_PC_MUX_OUT, WB_FLUSH, WB_STALL, WB_CS;
    logic [11:0]     WB_CSR_ADDR;

    int n_chk = 0;
    int n_fail = 0;

    wb_trap_commit #(.XLEN(XLEN), .CSR_AW(12)) dut (
        .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_IR(WB_IR), .WB_PC(WB_PC), .WB_NPC(WB_NPC),
        .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_RFD(WB_RFD),
        .WB_CSRFD(WB_CSRFD), .WB_DRID(WB_DRID), .WB_PC_MUX(WB_PC_MUX), .WB_BADADDR(WB_BADADDR),
        .WB_ECALL(WB_ECALL), .F_IAM(F_IAM), .F_IAF(F_IAF), .F_II(F_II), .MEM_LAM(MEM_LAM),
        .MEM_LAF(MEM_LAF), .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF), .TIMER(TIMER),
        .EXTERNAL(EXTERNAL), .MIE(MIE), .PRIVILEGE(PRIVILEGE), .MTVEC(MTVEC), .MEPC(MEPC),
        .WB_RF_DATA(WB_RF_DATA), .WB_DRID_OUT(WB_DRID_OUT), .WB_ST_REG(WB_ST_REG),
        .WB_CSR_DATA(WB_CSR_DATA), .WB_CSR_ADDR(WB_CSR_ADDR), .WB_ST_CSR(WB_ST_CSR),
        .WB_BR_JMP_TARGET(WB_BR_JMP_TARGET), .WB_PC_MUX_OUT(WB_PC_MUX_OUT), .WB_FLUSH(WB_FLUSH),
        .WB_STALL(WB_STALL), .WB_CAUSE(WB_CAUSE), .WB_CS(WB_CS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        WB_V = 0; WB_IR = 32'h13; WB_PC_MUX = 0; WB_DRID = 0;
        WB_ECALL = 0; F_IAM = 0; F_IAF = 0; F_II = 0;
        MEM_LAM = 0; MEM_LAF = 0; MEM_SAM = 0; MEM_SAF = 0;
        TIMER = 0; EXTERNAL = 0;
    endtask

    // Caller presents the trapping instruction; this walks the whole sequence.
    task automatic trap_seq(input string t, input logic [63:0] epc, input logic [63:0] cause,
                            input logic [63:0] tval, input logic [63:0] tgt);
        step();
        chk({t, ".epc_st"}, 64'(WB_ST_CSR), 64'd1);
        chk({t, ".epc_addr"}, 64'(WB_CSR_ADDR), 64'h341);
        chk({t, ".epc_data"}, WB_CSR_DATA, epc);
        chk({t, ".epc_stall"}, 64'(WB_STALL), 64'd1);
        chk({t, ".no_rf"}, 64'(WB_ST_REG), 64'd0);
        chk({t, ".no_redir"}, 64'(WB_PC_MUX_OUT), 64'd0);
        clr();
        step();
        chk({t, ".cause_addr"}, 64'(WB_CSR_ADDR), 64'h342);
        chk({t, ".cause_data"}, WB_CSR_DATA, cause);
        chk({t, ".cause_stall"}, 64'(WB_STALL), 64'd1);
        chk({t, ".cause_lat"}, WB_CAUSE, cause);
        step();
        chk({t, ".tval_addr"}, 64'(WB_CSR_ADDR), 64'h343);
        chk({t, ".tval_data"}, WB_CSR_DATA, tval);
        chk({t, ".tval_stall"}, 64'(WB_STALL), 64'd1);
        step();
        chk({t, ".rd_pcmux"}, 64'(WB_PC_MUX_OUT), 64'd1);
        chk({t, ".rd_tgt"}, WB_BR_JMP_TARGET, tgt);
        chk({t, ".rd_flush"}, 64'(WB_FLUSH), 64'd1);
        chk({t, ".rd_cs"}, 64'(WB_CS), 64'd1);
        chk({t, ".rd_stall"}, 64'(WB_STALL), 64'd0);
        chk({t, ".rd_stcsr"}, 64'(WB_ST_CSR), 64'd0);
        step();
        chk({t, ".idle_pcmux"}, 64'(WB_PC_MUX_OUT), 64'd0);
        chk({t, ".idle_cs"}, 64'(WB_CS), 64'd0);
    endtask

    initial begin
        RESET = 1; clr();
        WB_PC = 0; WB_NPC = 0; WB_ALU_RESULT = 0; WB_MEM_RESULT = 0; WB_RFD = 0; WB_CSRFD = 0;
        WB_BADADDR = 0; MIE = 0; PRIVILEGE = 0; MTVEC = 64'h8000; MEPC = 0;
        step(); step();
        chk("rst.st_reg", 64'(WB_ST_REG), 0);
        chk("rst.st_csr", 64'(WB_ST_CSR), 0);
        chk("rst.stall", 64'(WB_STALL), 0);
        chk("rst.cause", WB_CAUSE, 0);
        chk("rst.pcmux", 64'(WB_PC_MUX_OUT), 0);
        RESET = 0;

        // load, rd=5
        WB_V = 1; WB_IR = 32'h0000_0003; WB_DRID = 5; WB_MEM_RESULT = 64'hDEAD;
        step();
        chk("ld.data", WB_RF_DATA, 64'hDEAD);
        chk("ld.drid", 64'(WB_DRID_OUT), 5);
        chk("ld.st", 64'(WB_ST_REG), 1);
        chk("ld.stall", 64'(WB_STALL), 0);
        WB_DRID = 0;
        step();
        chk("ld0.st", 64'(WB_ST_REG), 0);
        clr();
        step();
        chk("nov.st", 64'(WB_ST_REG), 0);

        // ALU op
        WB_V = 1; WB_IR = 32'h0000_0013; WB_DRID = 7; WB_ALU_RESULT = 64'h55;
        step();
        chk("alu.data", WB_RF_DATA, 64'h55);
        chk("alu.st", 64'(WB_ST_REG), 1);

        // JAL taken
        WB_IR = 32'h0000_006F; WB_DRID = 1; WB_PC_MUX = 1; WB_NPC = 64'h1004; WB_ALU_RESULT = 64'h2000;
        step();
        chk("jal.data", WB_RF_DATA, 64'h1004);
        chk("jal.pcmux", 64'(WB_PC_MUX_OUT), 1);
        chk("jal.tgt", WB_BR_JMP_TARGET, 64'h2000);
        chk("jal.flush", 64'(WB_FLUSH), 1);

        // csrrw x5, 0x300
        WB_PC_MUX = 0; WB_IR = 32'h3000_12F3; WB_DRID = 5; WB_RFD = 64'h11; WB_CSRFD = 64'h22;
        step();
        chk("csr.rf", WB_RF_DATA, 64'h11);
        chk("csr.st", 64'(WB_ST_CSR), 1);
        chk("csr.addr", 64'(WB_CSR_ADDR), 64'h300);
        chk("csr.data", WB_CSR_DATA, 64'h22);
        chk("csr.flush", 64'(WB_FLUSH), 0);

        // illegal instruction on a load
        clr();
        WB_V = 1; WB_IR = 32'h0000_0003; WB_DRID = 5; F_II = 1;
        WB_PC = 64'h100; WB_BADADDR = 64'hFFFF; MTVEC = 64'h8000;
        trap_seq("ii", 64'h100, 64'd2, 64'hFFFF, 64'h8000);

        // F_II outranks F_IAM
        WB_V = 1; F_II = 1; F_IAM = 1; WB_PC = 64'h104;
        trap_seq("prio", 64'h104, 64'd2, 64'hFFFF, 64'h8000);

        // timer interrupt beats load fault, vectored mtvec
        WB_V = 1; TIMER = 1; MEM_LAF = 1; MIE = 1; MTVEC = 64'h8001;
        WB_PC = 64'h200; WB_BADADDR = 64'h1234;
        trap_seq("tmr", 64'h200, 64'h8000_0000_0000_0007, 64'd0, 64'h801C);
        MIE = 0;

        // ecall from U then M
        MTVEC = 64'h8000; WB_BADADDR = 64'h5555;
        WB_V = 1; WB_IR = 32'h0000_0073; WB_ECALL = 1; PRIVILEGE = 0; WB_PC = 64'h300;
        trap_seq("ecu", 64'h300, 64'd8, 64'd0, 64'h8000);
        WB_V = 1; WB_IR = 32'h0000_0073; WB_ECALL = 1; PRIVILEGE = 1; WB_PC = 64'h304;
        trap_seq("ecm", 64'h304, 64'd11, 64'd0, 64'h8000);

        // mret
        WB_V = 1; WB_IR = 32'h3020_0073; WB_DRID = 0; MEPC = 64'h400;
        step();
        chk("mret.pcmux", 64'(WB_PC_MUX_OUT), 1);
        chk("mret.tgt", WB_BR_JMP_TARGET, 64'h400);
        chk("mret.flush", 64'(WB_FLUSH), 1);
        chk("mret.st_reg", 64'(WB_ST_REG), 0);
        chk("mret.st_csr", 64'(WB_ST_CSR), 0);

        // pending interrupt without a valid instruction is not taken
        clr(); MIE = 1; TIMER = 1;
        step();
        chk("nov_irq.stall", 64'(WB_STALL), 0);
        chk("nov_irq.st_csr", 64'(WB_ST_CSR), 0);
        clr(); MIE = 0;

        // reset aborts a trap in W_CAUSE
        WB_V = 1; F_II = 1; WB_PC = 64'h500; WB_BADADDR = 64'h77;
        step();
        clr();
        step();
        chk("abort.wcause", 64'(WB_CSR_ADDR), 64'h342);
        RESET = 1;
        step();
        chk("abort.stall", 64'(WB_STALL), 0);
        chk("abort.st_csr", 64'(WB_ST_CSR), 0);
        chk("abort.pcmux", 64'(WB_PC_MUX_OUT), 0);
        chk("abort.cause", WB_CAUSE, 0);
        RESET = 0;
        step();
        chk("abort.no_redir", 64'(WB_PC_MUX_OUT), 0);
        WB_V = 1; WB_IR = 32'h0000_0003; WB_DRID = 9; WB_MEM_RESULT = 64'hBEEF;
        step();
        chk("post.data", WB_RF_DATA, 64'hBEEF);
        chk("post.st", 64'(WB_ST_REG), 1);
        chk("post.stall", 64'(WB_STALL), 0);
        clr();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
